// File: rtl/pll_drp_reconfig.sv
`default_nettype none
// ============================================================================
// Module   : pll_drp_reconfig
// Brief    : DRP master that reprograms a 7-series PLL at run time. Holds the
//            PLL in reset, walks a read-modify-write table over DRP, then
//            releases reset and waits for a synchronized LOCKED.
// Options  : define PLL_DRP_READBACK_EN to re-read each written register and
//            abort on mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module pll_drp_reconfig #(
  parameter int NUM_ENTRIES  = 23,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [6:0]  tbl_idx,
  input  logic [6:0]  tbl_addr,
  input  logic [15:0] tbl_mask,
  input  logic [15:0] tbl_data,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked
);

  // One shared counter serves both the DRDY and the lock timeouts.
  localparam int CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ASSERT_RST,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
`ifdef PLL_DRP_READBACK_EN
    S_VERIFY,
    S_VERIFY_WAIT,
`endif
    S_NEXT,
    S_RELEASE,
    S_LOCK_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [6:0]  tbl_idx_q, tbl_idx_d;
  logic [6:0]  daddr_q, daddr_d;
  logic        den_q, den_d;
  logic        dwe_q, dwe_d;
  logic [15:0] di_q, di_d;
  logic        pll_rst_q, pll_rst_d;
  logic        lock_meta_q, lock_meta_d;
  logic        lock_sync_q, lock_sync_d;

  logic        drdy_expired;
  logic        lock_expired;

  assign drdy_expired = (cnt_q == CW'(DRDY_TIMEOUT - 1));
  assign lock_expired = (cnt_q == CW'(LOCK_TIMEOUT - 1));

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign tbl_idx   = tbl_idx_q;
  assign drp_daddr = daddr_q;
  assign drp_den   = den_q;
  assign drp_dwe   = dwe_q;
  assign drp_di    = di_q;
  assign pll_rst   = pll_rst_q;

  // Next-state and registered-output computation for the reconfiguration FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    tbl_idx_d   = tbl_idx_q;
    daddr_d     = daddr_q;
    den_d       = 1'b0;
    dwe_d       = 1'b0;
    di_d        = di_q;
    pll_rst_d   = pll_rst_q;
    lock_meta_d = pll_locked;
    lock_sync_d = lock_meta_q;

    case (state_q)
      S_IDLE: begin
        // done_q high means this is the done cycle: a start here is dropped.
        if (start && !done_q) begin
          error_d   = 1'b0;
          tbl_idx_d = 7'd0;
          pll_rst_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_ASSERT_RST;
        end
      end
      S_ASSERT_RST: state_d = S_RD;
      S_RD: begin
        daddr_d = tbl_addr;
        den_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (drp_drdy) begin
          di_d    = (drp_do & ~tbl_mask) | (tbl_data & tbl_mask);
          state_d = S_WR;
        end else if (drdy_expired) begin
          error_d = 1'b1;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR: begin
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (drp_drdy) begin
`ifdef PLL_DRP_READBACK_EN
          state_d = S_VERIFY;
`else
          state_d = S_NEXT;
`endif
        end else if (drdy_expired) begin
          error_d = 1'b1;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef PLL_DRP_READBACK_EN
      S_VERIFY: begin
        den_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_VERIFY_WAIT;
      end
      S_VERIFY_WAIT: begin
        if (drp_drdy) begin
          if (drp_do != di_q) begin
            error_d = 1'b1;
            state_d = S_RELEASE;
          end else begin
            state_d = S_NEXT;
          end
        end else if (drdy_expired) begin
          error_d = 1'b1;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_NEXT: begin
        if (tbl_idx_q == 7'(NUM_ENTRIES - 1)) begin
          state_d = S_RELEASE;
        end else begin
          tbl_idx_d = tbl_idx_q + 7'd1;
          state_d   = S_RD;
        end
      end
      S_RELEASE: begin
        pll_rst_d = 1'b0;
        cnt_d     = '0;
        state_d   = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (lock_sync_q) begin
          // An aborted walk still waits for lock but never reports done.
          done_d  = !error_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (lock_expired) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, output and lock-synchronizer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      tbl_idx_q   <= 7'd0;
      daddr_q     <= 7'd0;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      di_q        <= 16'd0;
      pll_rst_q   <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      tbl_idx_q   <= tbl_idx_d;
      daddr_q     <= daddr_d;
      den_q       <= den_d;
      dwe_q       <= dwe_d;
      di_q        <= di_d;
      pll_rst_q   <= pll_rst_d;
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_drp_reconfig.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_drp_reconfig
// Brief    : Directed self-checking bench for pll_drp_reconfig with a small
//            behavioural PLL DRP/LOCKED model. Honours PLL_DRP_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_drp_reconfig;

  localparam int NUM_ENTRIES  = 2;
  localparam int DRDY_TIMEOUT = 64;
  localparam int LOCK_TIMEOUT = 300;
  localparam int DLY          = 3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy, done, error;
  logic [6:0]  tbl_idx;
  logic [6:0]  tbl_addr;
  logic [15:0] tbl_mask, tbl_data;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        pll_rst;
  logic        pll_locked;

  pll_drp_reconfig #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .DRDY_TIMEOUT(DRDY_TIMEOUT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .tbl_idx   (tbl_idx),
    .tbl_addr  (tbl_addr),
    .tbl_mask  (tbl_mask),
    .tbl_data  (tbl_data),
    .drp_daddr (drp_daddr),
    .drp_den   (drp_den),
    .drp_dwe   (drp_dwe),
    .drp_di    (drp_di),
    .drp_do    (drp_do),
    .drp_drdy  (drp_drdy),
    .pll_rst   (pll_rst),
    .pll_locked(pll_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reconfiguration table: combinational lookup on tbl_idx.
  always_comb begin
    tbl_addr = 7'd0;
    tbl_mask = 16'd0;
    tbl_data = 16'd0;
    case (tbl_idx)
      7'd0: begin tbl_addr = 7'h08; tbl_mask = 16'h0FFF; tbl_data = 16'h0082; end
      7'd1: begin tbl_addr = 7'h09; tbl_mask = 16'hF000; tbl_data = 16'hA000; end
      default: ;
    endcase
  end

  // Bench controls for the PLL model (written only by the stimulus block).
  bit lock_en = 1'b1;
  bit corrupt = 1'b0;
  int drop_at = -1;

  // PLL DRP model state (written only by the model).
  logic [15:0] mem [128];
  logic [15:0] rdata;
  bit          pend = 1'b0;
  int          dly_cnt = 0;
  int          rd_cnt = 0;
  bit          den_overlap = 1'b0;
  bit          den_no_rst = 1'b0;
  int          lock_cnt = 0;

  // DRP register file: answers each DEN with DRDY after a fixed delay.
  always @(posedge clk) begin
    drp_drdy <= 1'b0;
    if (!rst_n) begin
      pend <= 1'b0;
      for (int k = 0; k < 128; k++) mem[k] <= 16'h0000;
      mem[8] <= 16'h1041;
      mem[9] <= 16'h1234;
    end else begin
      if (pend) begin
        if (dly_cnt <= 1) begin
          drp_drdy <= 1'b1;
          drp_do   <= rdata;
          pend     <= 1'b0;
        end else begin
          dly_cnt <= dly_cnt - 1;
        end
      end
      if (drp_den) begin
        if (pend) den_overlap <= 1'b1;
        if (!pll_rst) den_no_rst <= 1'b1;
        if (drp_dwe) begin
          mem[drp_daddr] <= corrupt ? (drp_di ^ 16'h0001) : drp_di;
          pend    <= 1'b1;
          dly_cnt <= DLY;
        end else begin
          rdata  <= mem[drp_daddr];
          rd_cnt <= rd_cnt + 1;
          if (rd_cnt != drop_at) begin
            pend    <= 1'b1;
            dly_cnt <= DLY;
          end
        end
      end
    end
  end

  // LOCKED model: rises 9 cycles after RST is released, if enabled.
  always @(posedge clk) begin
    if (pll_rst || !lock_en) begin
      lock_cnt   <= 0;
      pll_locked <= 1'b0;
    end else if (lock_cnt < 8) begin
      lock_cnt <= lock_cnt + 1;
    end else begin
      pll_locked <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by run().
  int          nrd, nwr, n_done, busy_rises;
  int          err_cyc, rd2_cyc, rst_fall, lock_cyc, done_cyc;
  int          max_idx;
  bit          timed_out;
  logic        busy_after, err_after, rst_after, rst_after_err;
  logic [15:0] first_wr_di;
  logic [6:0]  first_rd_addr, first_rd_idx;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse (or hold) start and observe until busy falls or the budget expires.
  task automatic run(input int max_cyc, input bit hold);
    logic prev_busy;
    nrd = 0; nwr = 0; n_done = 0; busy_rises = 0; max_idx = 0;
    err_cyc = -1; rd2_cyc = -1; rst_fall = -1; lock_cyc = -1; done_cyc = -1;
    timed_out = 1'b1; rst_after_err = 1'b1;
    first_wr_di = 16'h0; first_rd_addr = 7'h7F; first_rd_idx = 7'h7F;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    busy_after = busy;
    err_after  = error;
    rst_after  = pll_rst;
    prev_busy  = busy;
    busy_rises = busy ? 1 : 0;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (drp_den && !drp_dwe) begin
        nrd++;
        if (nrd == 1) begin first_rd_addr = drp_daddr; first_rd_idx = tbl_idx; end
        if (nrd == 2) rd2_cyc = i;
      end
      if (drp_den && drp_dwe) begin
        nwr++;
        if (nwr == 1) first_wr_di = drp_di;
      end
      if (int'(tbl_idx) > max_idx) max_idx = int'(tbl_idx);
      if (error && err_cyc < 0) err_cyc = i;
      if (err_cyc >= 0 && i == err_cyc + 1) rst_after_err = pll_rst;
      if (!pll_rst && rst_fall < 0) rst_fall = i;
      if (pll_locked && rst_fall >= 0 && lock_cyc < 0) lock_cyc = i;
      if (done) begin
        n_done++;
        done_cyc = i;
        if (hold) start = 1'b0;
      end
      if (busy && !prev_busy) busy_rises++;
      prev_busy = busy;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy",  {31'd0, busy},    32'd0);
    check("rst_done",  {31'd0, done},    32'd0);
    check("rst_error", {31'd0, error},   32'd0);
    check("rst_idx",   {25'd0, tbl_idx}, 32'd0);
    check("rst_daddr", {25'd0, drp_daddr}, 32'd0);
    check("rst_den",   {31'd0, drp_den}, 32'd0);
    check("rst_dwe",   {31'd0, drp_dwe}, 32'd0);
    check("rst_di",    {16'd0, drp_di},  32'd0);
    check("rst_pllrst",{31'd0, pll_rst}, 32'd0);
    rst_n = 1'b1;
    repeat (12) tick();

    // Nominal two-entry RMW: 0x08 0x1041 -> 0x1082, 0x09 0x1234 -> 0xA234
    run(400, 1'b0);
    check("t1_timeout",   {31'd0, timed_out},  32'd0);
    check("t1_busy_start",{31'd0, busy_after}, 32'd1);
    check("t1_rst_start", {31'd0, rst_after},  32'd1);
    check("t1_wr_di",     {16'd0, first_wr_di}, 32'h1082);
    check("t1_mem08",     {16'd0, mem[8]},     32'h1082);
    check("t1_mem09",     {16'd0, mem[9]},     32'hA234);
    check("t1_ndone",     n_done,              32'd1);
    check("t1_lock2done", done_cyc - lock_cyc, 32'd3);
    check("t1_error",     {31'd0, error},      32'd0);
    check("t1_busy_end",  {31'd0, busy},       32'd0);
    check("t1_den_rst",   {31'd0, den_no_rst}, 32'd0);
    check("t1_overlap",   {31'd0, den_overlap}, 32'd0);
    tick();
    check("t1_done_pulse",{31'd0, done},       32'd0);
    repeat (4) tick();

    // No DRDY on the second read: abort after DRDY_TIMEOUT, no done
    drop_at = rd_cnt + 1;
    run(400, 1'b0);
    drop_at = -1;
    check("t2_timeout",   {31'd0, timed_out},  32'd0);
    check("t2_err_time",  err_cyc - rd2_cyc,   32'd64);
    check("t2_rst_drop",  {31'd0, rst_after_err}, 32'd0);
    check("t2_ndone",     n_done,              32'd0);
    check("t2_error",     {31'd0, error},      32'd1);
    check("t2_lock_seen", {31'd0, pll_locked}, 32'd1);
    repeat (4) tick();

    // Lock withheld: lock timeout, then a clean retry clears error
    lock_en = 1'b0;
    run(LOCK_TIMEOUT + 200, 1'b0);
    check("t3_timeout",   {31'd0, timed_out},  32'd0);
    check("t3_err_clr",   {31'd0, err_after},  32'd0);
    check("t3_lock_time", err_cyc - rst_fall,  LOCK_TIMEOUT);
    check("t3_error",     {31'd0, error},      32'd1);
    check("t3_ndone",     n_done,              32'd0);
    lock_en = 1'b1;
    repeat (4) tick();
    run(400, 1'b0);
    check("t3b_err_clr",  {31'd0, err_after},  32'd0);
    check("t3b_ndone",    n_done,              32'd1);
    check("t3b_error",    {31'd0, error},      32'd0);
    repeat (4) tick();

    // start held high for the whole sequence: exactly one run
    run(400, 1'b1);
    check("t4_timeout",   {31'd0, timed_out},  32'd0);
    check("t4_rises",     busy_rises,          32'd1);
    check("t4_nrd",       nrd,                 32'd2);
    check("t4_maxidx",    max_idx,             32'd1);
    check("t4_ndone",     n_done,              32'd1);
    tick();
    check("t4_idle",      {31'd0, busy},       32'd0);
    repeat (4) tick();

    // rst_n low during WR_WAIT
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60 && !(drp_den && drp_dwe); i++) tick();
    check("t5_saw_wr",    {31'd0, drp_den & drp_dwe}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("t5_pllrst",    {31'd0, pll_rst},    32'd0);
    check("t5_den",       {31'd0, drp_den},    32'd0);
    check("t5_busy",      {31'd0, busy},       32'd0);
    check("t5_idx",       {25'd0, tbl_idx},    32'd0);
    rst_n = 1'b1;
    repeat (12) tick();
    run(400, 1'b0);
    check("t5_rd_addr",   {25'd0, first_rd_addr}, 32'h08);
    check("t5_rd_idx",    {25'd0, first_rd_idx},  32'd0);
    check("t5_ndone",     n_done,              32'd1);
    repeat (4) tick();

    // Model corrupts bit 0 of every written value
    corrupt = 1'b1;
    run(400, 1'b0);
    corrupt = 1'b0;
    check("t6_timeout",   {31'd0, timed_out},  32'd0);
`ifdef PLL_DRP_READBACK_EN
    check("t6_error",     {31'd0, error},      32'd1);
    check("t6_ndone",     n_done,              32'd0);
    check("t6_nwr",       nwr,                 32'd1);
`else
    check("t6_error",     {31'd0, error},      32'd0);
    check("t6_ndone",     n_done,              32'd1);
    check("t6_nwr",       nwr,                 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
